// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
package rom_arbiter_pkg;

  // Requester identifier: one bit covers the two ports.
  typedef logic req_id_t;

  localparam req_id_t REQ0        = 1'b0;
  localparam req_id_t REQ1        = 1'b1;
  localparam int      MAX_LATENCY = 4;

  // One in-flight read: whether a read was issued and who issued it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rom_tag_t;

  // Collapse a two-way one-hot grant into a requester id.
  function automatic req_id_t grant_to_id(logic [1:0] grant);
    return grant[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way grant logic, purely combinational so other shared-memory
// arbiters can reuse it with their own last-grant register.
module rom_arb_rr
  import rom_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  input  logic       fixed_priority,
  output logic [1:0] grant
);

  // Lone requester always wins; a tie goes to requester 0 under fixed
  // priority, otherwise to whoever was not granted last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (fixed_priority)          grant = 2'b01;
        else if (last_grant == REQ0) grant = 2'b10;
        else                         grant = 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-output ROM between two requesters. A grant edge
// drives the ROM address/enable and pushes a tag; the tag emerges
// LATENCY+1 edges later, exactly when the ROM word is valid, and steers
// that word to the issuing requester's data register.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int LATENCY        = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic                  valid0,
  output logic [DATA_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic                  valid1,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  logic [1:0]                 req;
  logic [1:0]                 grant;
  logic                       any_req;
  req_id_t                    last_grant;
  req_id_t                    win_id;
  rom_tag_t [LATENCY:0]       tag_pipe;
  rom_tag_t                   ret_tag;
  logic                       ret0;
  logic                       ret1;

  assign req     = {req1, req0};
  assign any_req = |req;
  assign win_id  = grant_to_id(grant);

  rom_arb_rr u_arb (
    .req            (req),
    .last_grant     (last_grant),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (grant)
  );

  // Grant edge: register ROM address/enable and the ack pulse. The address
  // is left untouched on idle cycles; last_grant resets to 1 so the first
  // tie goes to requester 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_enable  <= 1'b0;
      rom_address <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      last_grant  <= REQ1;
    end else begin
      rom_enable <= any_req;
      ack0       <= grant[0];
      ack1       <= grant[1];
      if (any_req) begin
        rom_address <= grant[1] ? addr1 : addr0;
        last_grant  <= win_id;
      end
    end
  end

  // Tag shift register: one stage per clock of ROM latency plus the
  // address register, so the last stage lines up with valid rom_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tag_pipe <= '0;
    else          tag_pipe <= {tag_pipe[LATENCY-1:0], rom_tag_t'{valid: any_req, id: win_id}};
  end

  assign ret_tag = tag_pipe[LATENCY];
  assign ret0    = ret_tag.valid && (ret_tag.id == REQ0);
  assign ret1    = ret_tag.valid && (ret_tag.id == REQ1);

  // Return path: rom_q is only sampled when a valid tag emerges, and only
  // into the port named by that tag; data holds between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      data0  <= '0;
      data1  <= '0;
    end else begin
      valid0 <= ret0;
      valid1 <= ret1;
      if (ret0) data0 <= rom_q;
      if (ret1) data1 <= rom_q;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Three arbiter configurations side by side (round-robin, fixed priority,
// latency 3), each with its own ROM model, reference model and checker.
module tb_rom_arbiter;

  localparam int NI = 3;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] d;
  } ret_t;

  function automatic logic [7:0] romw(logic [13:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0 [NI];
  logic        r1 [NI];
  logic [13:0] a0 [NI];
  logic [13:0] a1 [NI];
  logic        k0 [NI];
  logic        k1 [NI];
  logic        v0 [NI];
  logic        v1 [NI];
  logic        en [NI];
  logic [7:0]  d0 [NI];
  logic [7:0]  d1 [NI];
  logic [7:0]  rq [NI];
  logic [13:0] ra [NI];

  int ntm = 0;
  int nfm = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : gc
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int FP  = (g == 1) ? 1 : 0;

    int nt = 0;
    int nf = 0;

    rom_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .LATENCY(LAT), .FIXED_PRIORITY(FP)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0        (r0[g]),
      .addr0       (a0[g]),
      .ack0        (k0[g]),
      .valid0      (v0[g]),
      .data0       (d0[g]),
      .req1        (r1[g]),
      .addr1       (a1[g]),
      .ack1        (k1[g]),
      .valid1      (v1[g]),
      .data1       (d1[g]),
      .rom_address (ra[g]),
      .rom_enable  (en[g]),
      .rom_q       (rq[g])
    );

    // ROM: registered, LAT-deep; garbage out when the enable was low.
    logic [7:0] rp [LAT];
    always @(posedge clock) begin
      rp[0] <= en[g] ? romw(ra[g]) : 8'($urandom);
      for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
    end
    assign rq[g] = rp[LAT-1];

    // Reference model: per-edge arbitration decision and a queue of
    // returns due at edge number (grant edge + LAT + 1).
    logic        e_k0 = 0, e_k1 = 0, e_en = 0, e_v0 = 0, e_v1 = 0;
    logic [13:0] e_ra = '0;
    logic [7:0]  e_d0 = '0, e_d1 = '0;
    bit          lg   = 1'b1;
    int          cyc  = 0;
    int          dw0  = 0, dw1 = 0;
    ret_t        pend [$];

    always @(posedge clock or negedge reset_n) begin
      bit   any, win;
      ret_t rt;
      if (!reset_n) begin
        e_k0 = 0; e_k1 = 0; e_en = 0; e_v0 = 0; e_v1 = 0;
        e_ra = '0; e_d0 = '0; e_d1 = '0; lg = 1'b1; cyc = 0;
        pend.delete();
      end else begin
        cyc++;
        e_v0 = 0; e_v1 = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          rt = pend.pop_front();
          if (rt.id) begin e_v1 = 1; e_d1 = rt.d; end
          else       begin e_v0 = 1; e_d0 = rt.d; end
        end
        any = r0[g] | r1[g];
        if (r0[g] && r1[g]) win = (FP != 0) ? 1'b0 : !lg;
        else                win = r1[g];
        e_k0 = any && !win;
        e_k1 = any && win;
        e_en = any;
        if (any) begin
          e_ra = win ? a1[g] : a0[g];
          lg   = win;
          pend.push_back('{cyc + LAT + 1, win, romw(e_ra)});
        end
      end
    end

    // Compare every cycle; in round-robin mode also bound how long a held
    // request may go ungranted.
    always @(negedge clock) begin
      nt++;
      if ({k0[g], k1[g], en[g], ra[g]} !== {e_k0, e_k1, e_en, e_ra}) begin
        nf++;
        $display("FAIL grant[%0d] t=%0t got ack=%b%b en=%b addr=%h want ack=%b%b en=%b addr=%h",
                 g, $time, k1[g], k0[g], en[g], ra[g], e_k1, e_k0, e_en, e_ra);
      end
      nt++;
      if ({v0[g], v1[g], d0[g], d1[g]} !== {e_v0, e_v1, e_d0, e_d1}) begin
        nf++;
        $display("FAIL return[%0d] t=%0t got v=%b%b d0=%h d1=%h want v=%b%b d0=%h d1=%h",
                 g, $time, v1[g], v0[g], d0[g], d1[g], e_v1, e_v0, e_d0, e_d1);
      end
      if (!reset_n) begin
        dw0 = 0; dw1 = 0;
      end else if (FP == 0) begin
        dw0 = (r0[g] && !k0[g]) ? dw0 + 1 : 0;
        dw1 = (r1[g] && !k1[g]) ? dw1 + 1 : 0;
        if (r0[g] || r1[g]) begin
          nt++;
          if (dw0 > 1 || dw1 > 1) begin
            nf++;
            $display("FAIL starve[%0d] t=%0t waits got %0d/%0d want <2", g, $time, dw0, dw1);
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic chk(string nm, int g, logic [63:0] act, logic [63:0] exp);
    ntm++;
    if (act !== exp) begin
      nfm++;
      $display("FAIL %s[%0d] t=%0t got %0h want %0h", nm, g, $time, act, exp);
    end
  endtask

  task automatic chk_idle(string nm, int g);
    chk(nm, g, {k0[g], k1[g], v0[g], v1[g], en[g], ra[g], d0[g], d1[g]}, 64'h0);
  endtask

  function automatic logic [13:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
  endfunction

  initial begin
    logic [7:0] seq5 [4];
    int         tr, tf;
    seq5 = '{8'h59, 8'h58, 8'h5B, 8'h5A};
    for (int g = 0; g < NI; g++) begin
      r0[g] = 0; r1[g] = 0; a0[g] = '0; a1[g] = '0;
    end

    // 1: reset state
    repeat (10) tick();
    for (int g = 0; g < NI; g++) chk_idle("reset", g);
    reset_n = 1'b1;

    // 2: single read by requester 0
    r0[0] = 1; a0[0] = 14'h0010;
    tick();
    chk("t2_ack", 0, {k0[0], k1[0], en[0], ra[0]}, {1'b1, 1'b0, 1'b1, 14'h0010});
    r0[0] = 0;
    tick();
    chk("t2_idle", 0, {k0[0], en[0], v0[0]}, 3'b000);
    tick();
    chk("t2_ret", 0, {v0[0], v1[0], d0[0], d1[0]}, {1'b1, 1'b0, 8'hB5, 8'h00});
    tick();
    chk("t2_hold", 0, {v0[0], d0[0]}, {1'b0, 8'hB5});

    // 3/4: both held, round-robin (g0) vs fixed priority (g1)
    reset_n = 0;
    tick();
    reset_n = 1;
    for (int g = 0; g < 2; g++) begin
      r0[g] = 1; r1[g] = 1; a0[g] = 14'h0001; a1[g] = 14'h0002;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_alt", 0, {k0[0], k1[0]}, {1'(i % 2 == 0), 1'(i % 2 == 1)});
      chk("t4_fix", 1, {k0[1], k1[1]}, 2'b10);
      if (i >= 2) begin
        chk("t3_vld", 0, {v0[0], v1[0]}, {1'(i % 2 == 0), 1'(i % 2 == 1)});
        if (v0[0]) chk("t3_d0", 0, d0[0], 8'hA4);
        if (v1[0]) chk("t3_d1", 0, d1[0], 8'hA7);
      end
    end
    r0[0] = 0; r1[0] = 0; r0[1] = 0;
    tick();
    chk("t4_rel", 1, {k0[1], k1[1]}, 2'b01);
    r1[1] = 0;

    // 5: latency 3, streaming the top of the address space
    r1[2] = 1; a1[2] = 14'h3FFC;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 4) chk("t5_ack", 2, k1[2], 1'b1);
      if (i < 3) a1[2] = 14'h3FFD + 14'(i);
      else       r1[2] = 0;
      chk("t5_vld", 2, v1[2], 1'(i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) chk("t5_d1", 2, d1[2], seq5[i-4]);
    end

    // 6: reset lands on the return edge
    r0[0] = 1; a0[0] = 14'h0020;
    tick();
    chk("t6_ack", 0, k0[0], 1'b1);
    r0[0] = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_noret", 0, {v0[0], v1[0], d0[0]}, 10'h0);
    end
    r0[0] = 1; r1[0] = 1; a0[0] = 14'h0005; a1[0] = 14'h0006;
    tick();
    chk("t6_tie", 0, {k0[0], k1[0]}, 2'b10);
    r0[0] = 0; r1[0] = 0;

    // Random traffic with the hold-until-ack protocol, plus a mid-cycle reset
    for (int it = 0; it < 600; it++) begin
      tick();
      if (it == 300) begin
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        for (int g = 0; g < NI; g++) chk_idle("async_rst", g);
        tick();
        reset_n = 1;
      end
      for (int g = 0; g < NI; g++) begin
        if (!r0[g] || k0[g]) begin
          r0[g] = ($urandom_range(0, 9) < 7);
          a0[g] = rnd_addr();
        end
        if (!r1[g] || k1[g]) begin
          r1[g] = ($urandom_range(0, 9) < 7);
          a1[g] = rnd_addr();
        end
      end
    end
    for (int g = 0; g < NI; g++) begin r0[g] = 0; r1[g] = 0; end
    repeat (8) tick();

    tr = ntm + gc[0].nt + gc[1].nt + gc[2].nt;
    tf = nfm + gc[0].nf + gc[1].nf + gc[2].nf;
    $display("[TB] %0d tests run, %0d failed", tr, tf);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM (registered output, enable-gated read) between two requesters, e.g. the Z80 bus fetch path and a preload/copy engine.
- Arbitrates request slots, drives the ROM address and enable, and tracks in-flight reads through a tag pipeline.
- Returns each ROM word to the requester that issued it, and holds that word until the requester's next read completes.

Parameters:
- ADDR_WIDTH, 14, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- LATENCY, 1, ROM read latency in clocks from address-sampling edge to valid q; legal range 1..4.
- FIXED_PRIORITY, 0. 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 read request; held with addr0 until ack0.
- addr0  in  ADDR_WIDTH  requester 0 read address.
- ack0  out  1  one-cycle pulse: request 0 accepted.
- valid0  out  1  one-cycle pulse: data0 updated.
- data0  out  DATA_WIDTH  last word returned to requester 0.
- req1/addr1/ack1/valid1/data1  same as above, for requester 1.
- rom_address  out  ADDR_WIDTH  to ROM address.
- rom_enable  out  1  to ROM enable.
- rom_q  in  DATA_WIDTH  from ROM q; undefined/high-Z whenever its enable was low.

Behaviour:
- Reset (async assert, sync release): ack*, valid*, rom_enable = 0; data*, rom_address = 0; tag pipeline cleared; last_grant = 1, so requester 0 wins the first tie.
- Grant edge E0 (any req high):
  - If one requester is high, it wins.
  - If both are high: FIXED_PRIORITY=1 picks requester 0; otherwise the requester not in last_grant wins.
  - Registers driven: rom_enable=1, rom_address=winner addr, ack_winner=1, last_grant=winner.
  - Tag pipeline stage 0 loaded with {1, winner id}.
- No req at E0: rom_enable=0, ack*=0, rom_address holds its previous value, tag stage 0 = {0, x}.
- Requester rule: ack is seen in the cycle after E0. Before E1 the requester must either deassert req or present the next address. A req still high at E1 is a new request, which allows back-to-back grants.
- ROM samples rom_address at E1. rom_q is valid after edge E_LATENCY.
- Tag pipeline depth is LATENCY+1. At edge E_(LATENCY+1), if the tag is valid: data_id <= rom_q and valid_id pulses for one cycle.
- Request-sample to valid latency = LATENCY+1 clocks. Throughput is one read per clock.
- rom_q is captured only when a valid tag emerges; the value on idle cycles is never sampled.
- data* holds its value between valid pulses.
- Starvation bound (round-robin): a requester held high is granted within 2 grant edges. FIXED_PRIORITY=1 may starve requester 1; this is documented and intended.
- No cross-requester data leakage: a tag id mismatch never updates the other port.
- Reset mid-operation: in-flight reads are discarded, no valid pulse follows, and the first grant after release goes to requester 0.
- Address wrap: no arithmetic on addresses. Full ADDR_WIDTH is passed through and all-ones is legal.

Decomposition:
- Package rom_arbiter_pkg:
  - typedef req_id_t (1 bit).
  - Constants REQ0=0, REQ1=1, MAX_LATENCY=4.
  - typedef rom_tag_t {logic valid; req_id_t id}.
- One sub-module rom_arb_rr:
  - Two-way grant logic: req[1:0], last_grant, fixed_priority -> grant one-hot.
  - Combinational, reused by other shared-memory arbiters.
- Tag shift register and data return logic stay in the top module.

Test Plan:
- ROM model: mem[i]=i[7:0]^8'hA5, LATENCY=1.
1. Reset only, 10 clocks -> all outputs 0; assert reset_n low mid-cycle -> outputs clear immediately, without waiting for a clock edge.
2. req0 pulse with addr0=14'h0010 -> ack0 after 1 edge; rom_address=0x0010, rom_enable=1 for 1 cycle; valid0 2 clocks after request sample; data0=0xB5; data1 unchanged.
3. req0 and req1 held high, addr0=0x0001, addr1=0x0002, round-robin -> grants alternate 0,1,0,1. valid pulses alternate; data0=0xA4 and data1=0xA7 on every return.
4. Same stimulus with FIXED_PRIORITY=1 -> ack0 every cycle, ack1 never; release req0 -> ack1 on the next grant edge.
5. LATENCY=3, req1 streaming addresses 0x3FFC..0x3FFF back-to-back -> valid1 4 clocks after each sample. data1 sequence 0x59,0x58,0x5B,0x5A, one per cycle.
6. Grant issued, then reset_n pulsed low 1 cycle before the return -> no valid0/valid1 after release; next tie grants requester 0.
